// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned MAX_HOLD_DEFAULT = 4;
    localparam int unsigned HOLD_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: sticky ownership with a bounded hold,
// combinational grant/memory steering and registered per-port load return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              gnt0;
    logic              gnt1;
    logic              at_max;

    assign at_max = (hold_cnt == HOLD_W'(MAX_HOLD));

    // State and hold counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Grant decision, next state and hold count
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = ST_IDLE;
        hold_nxt  = hold_cnt;

        unique case (state)
            ST_OWN0: begin
                if (m0_req && !(at_max && m1_req)) gnt0 = 1'b1;
                else if (m1_req)                   gnt1 = 1'b1;
            end
            ST_OWN1: begin
                if (m1_req && !(at_max && m0_req)) gnt1 = 1'b1;
                else if (m0_req)                   gnt0 = 1'b1;
            end
            default: begin
                if (m0_req)      gnt0 = 1'b1;
                else if (m1_req) gnt1 = 1'b1;
            end
        endcase

        // Grants are suppressed for as long as reset is held
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            state_nxt = ST_OWN0;
            if (state != ST_OWN0) hold_nxt = HOLD_W'(1);
            else if (!at_max)     hold_nxt = hold_cnt + HOLD_W'(1);
        end else if (gnt1) begin
            state_nxt = ST_OWN1;
            if (state != ST_OWN1) hold_nxt = HOLD_W'(1);
            else if (!at_max)     hold_nxt = hold_cnt + HOLD_W'(1);
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Steer the granted requester onto the memory port
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    // Load return: capture read data at the grant edge, pulse rvalid once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0 && !m0_we;
            m1_rvalid <= gnt1 && !m1_we;
            if (gnt0 && !m0_we) m0_rdata <= mem_rdata;
            if (gnt1 && !m1_we) m1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small memory model and a per-port
// load-return scoreboard.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_we;

    logic [DW-1:0] mem [128];
    assign mem_rdata = mem[7'(mem_addr >> 2)];

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          pend0 = 1'b0;
    logic          pend1 = 1'b0;
    logic [DW-1:0] last_rd0 = '0;
    logic [DW-1:0] last_rd1 = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0);
    endtask

    // One clock: check grants/memory port and load returns, update scoreboard.
    task automatic cyc(input string tag, input logic eg0, input logic eg1);
        logic [31:0] ea, ed;
        logic        ew;
        @(negedge clk);
        chk({tag, ":gnt0"}, 32'(m0_gnt), 32'(eg0));
        chk({tag, ":gnt1"}, 32'(m1_gnt), 32'(eg1));
        ea = eg0 ? m0_addr  : (eg1 ? m1_addr  : 32'h0);
        ed = eg0 ? m0_wdata : (eg1 ? m1_wdata : 32'h0);
        ew = eg0 ? m0_we    : (eg1 ? m1_we    : 1'b0);
        chk({tag, ":mem_we"},    32'(mem_we), 32'(ew));
        chk({tag, ":mem_addr"},  mem_addr,    ea);
        chk({tag, ":mem_wdata"}, mem_wdata,   ed);
        chk({tag, ":rvalid0"}, 32'(m0_rvalid), 32'(pend0));
        if (pend0 && q0.size() > 0) last_rd0 = q0.pop_front();
        chk({tag, ":rdata0"}, m0_rdata, last_rd0);
        chk({tag, ":rvalid1"}, 32'(m1_rvalid), 32'(pend1));
        if (pend1 && q1.size() > 0) last_rd1 = q1.pop_front();
        chk({tag, ":rdata1"}, m1_rdata, last_rd1);
        pend0 = eg0 && !m0_we;
        pend1 = eg1 && !m1_we;
        if (pend0) q0.push_back(mem[7'(m0_addr >> 2)]);
        if (pend1) q1.push_back(mem[7'(m1_addr >> 2)]);
        @(posedge clk);
        if (ew) mem[7'(ea >> 2)] = ed;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[4] = 32'hDEADBEEF;

        // Reset holds everything quiet even with both requesters active
        rst_n = 1'b0;
        set_m0(1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111);
        set_m1(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        #12;
        chk("rst:gnt0", 32'(m0_gnt), 32'h0);
        chk("rst:gnt1", 32'(m1_gnt), 32'h0);
        chk("rst:mem_we", 32'(mem_we), 32'h0);
        chk("rst:rvalid0", 32'(m0_rvalid), 32'h0);
        chk("rst:rvalid1", 32'(m1_rvalid), 32'h0);
        chk("rst:rdata0", m0_rdata, 32'h0);
        chk("rst:rdata1", m1_rdata, 32'h0);
        chk("rst:state", 32'(dut.state), 32'(ST_IDLE));
        chk("rst:hold", 32'(dut.hold_cnt), 32'h0);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        cyc("rel", 1'b0, 1'b0);

        // Single m0 load
        set_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        cyc("ld0", 1'b1, 1'b0);
        chk("ld0:hold", 32'(dut.hold_cnt), 32'h1);
        idle();
        cyc("ld0_rv", 1'b0, 1'b0);
        chk("ld0:data", m0_rdata, 32'hDEADBEEF);
        cyc("ld0_q", 1'b0, 1'b0);

        // Both requesting continuously from IDLE: m0 x4, m1 x4, m0 x4
        set_m0(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        set_m1(1'b1, 1'b0, 32'h0000_0030, 32'h0);
        for (int i = 0; i < 12; i++) begin
            cyc($sformatf("both%0d", i), (i / 4) != 1, (i / 4) == 1);
        end
        idle();
        cyc("both_tail", 1'b0, 1'b0);
        cyc("both_q", 1'b0, 1'b0);

        // m1 store to MMIO, then read it back through m0
        set_m1(1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678);
        cyc("st1", 1'b0, 1'b1);
        idle();
        cyc("st1_q", 1'b0, 1'b0);
        set_m0(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        cyc("rb0", 1'b1, 1'b0);
        idle();
        cyc("rb0_rv", 1'b0, 1'b0);
        chk("rb0:data", m0_rdata, 32'h1234_5678);

        // Saturating hold, forced handover, owner release, return to IDLE
        set_m0(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        for (int i = 0; i < 6; i++) cyc($sformatf("sat%0d", i), 1'b1, 1'b0);
        chk("sat:hold", 32'(dut.hold_cnt), 32'h4);
        set_m1(1'b1, 1'b0, 32'h0000_0008, 32'h0);
        cyc("hand1", 1'b0, 1'b1);
        chk("hand1:hold", 32'(dut.hold_cnt), 32'h1);
        set_m0(1'b0, 1'b0, '0, '0);
        cyc("keep1", 1'b0, 1'b1);
        chk("keep1:hold", 32'(dut.hold_cnt), 32'h2);
        set_m1(1'b0, 1'b0, '0, '0);
        set_m0(1'b1, 1'b0, 32'h0000_000C, 32'h0);
        cyc("rel1", 1'b1, 1'b0);
        chk("rel1:hold", 32'(dut.hold_cnt), 32'h1);
        idle();
        cyc("none", 1'b0, 1'b0);
        chk("none:state", 32'(dut.state), 32'(ST_IDLE));
        chk("none:hold", 32'(dut.hold_cnt), 32'h1);
        cyc("none_q", 1'b0, 1'b0);

        // Reset right after an m0 load grant drops the return
        set_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        set_m1(1'b1, 1'b1, 32'h0000_0108, 32'h5555_5555);
        @(negedge clk);
        chk("rg:gnt0", 32'(m0_gnt), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rg:gnt0_rst", 32'(m0_gnt), 32'h0);
        chk("rg:gnt1_rst", 32'(m1_gnt), 32'h0);
        chk("rg:mem_we_rst", 32'(mem_we), 32'h0);
        pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        last_rd0 = '0; last_rd1 = '0;
        @(posedge clk); #1;
        chk("rg:rvalid0", 32'(m0_rvalid), 32'h0);
        idle();
        @(negedge clk);
        chk("rg:rvalid0b", 32'(m0_rvalid), 32'h0);
        chk("rg:rdata0", m0_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rg:state", 32'(dut.state), 32'(ST_IDLE));
        cyc("rg_post", 1'b0, 1'b0);
        cyc("rg_post2", 1'b0, 1'b0);

        // Alternating single requests separated by idle cycles
        set_m0(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        cyc("alt0", 1'b1, 1'b0);
        chk("alt0:hold", 32'(dut.hold_cnt), 32'h1);
        idle();
        cyc("alt0_q", 1'b0, 1'b0);
        set_m1(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        cyc("alt1", 1'b0, 1'b1);
        chk("alt1:hold", 32'(dut.hold_cnt), 32'h1);
        idle();
        cyc("alt1_q", 1'b0, 1'b0);
        set_m0(1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D);
        cyc("alt2", 1'b1, 1'b0);
        chk("alt2:hold", 32'(dut.hold_cnt), 32'h1);
        idle();
        cyc("alt2_q", 1'b0, 1'b0);
        cyc("alt2_q2", 1'b0, 1'b0);

        chk("end:q0", 32'(q0.size()), 32'h0);
        chk("end:q1", 32'(q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
